// File: rtl/branch_update_arbiter.sv
// -----------------------------------------------------------------------------
// branch_update_arbiter
//
// Purpose:
//   Shares the single BTB update port among NREQ branch-resolution requesters.
//   A round-robin arbiter picks one requester per cycle. The accepted
//   resolution goes into a DEPTH-entry FIFO. The FIFO drains one entry per
//   cycle onto the BTB update port unless btb_stall holds the head.
//
// Configuration macro:
//   BRANCH_UPD_COALESCE_EN
//     When defined, a granted request whose PC matches the most recently
//     written entry overwrites that entry's outcome/target in place and does
//     not push. When undefined, no comparator is built.
//
// Parameters:
//   NREQ  : number of requesters (>= 2)
//   DEPTH : FIFO entries (power of two, >= 2)
//   CW    : width of count, $clog2(DEPTH+1)
//
// Ports:
//   CLK            in   clock, rising edge
//   nRST           in   asynchronous active-low reset
//   req_valid      in   [NREQ]     request valid per requester
//   req_ready      out  [NREQ]     one-hot grant/accept, or zero
//   req_pc         in   [NREQ*32]  branch PC, requester i at [32i+31:32i]
//   req_outcome    in   [NREQ]     resolved taken / not taken
//   req_target     in   [NREQ*32]  resolved target
//   flush          in   synchronous queue clear, highest priority
//   btb_stall      in   holds draining
//   update_btb     out  BTB write strobe (pop)
//   update_pc      out  head entry PC (0 when empty)
//   branch_outcome out  head entry outcome (0 when empty)
//   branch_target  out  head entry target (0 when empty)
//   count          out  valid entries
//   empty          out  count == 0
// -----------------------------------------------------------------------------
module branch_update_arbiter #(
  parameter  int NREQ  = 2,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_pc,
  input  logic [NREQ-1:0]    req_outcome,
  input  logic [NREQ*32-1:0] req_target,
  input  logic               flush,
  input  logic               btb_stall,
  output logic               update_btb,
  output logic [31:0]        update_pc,
  output logic               branch_outcome,
  output logic [31:0]        branch_target,
  output logic [CW-1:0]      count,
  output logic               empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int RW = $clog2(NREQ);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]   r_mem_pc  [DEPTH];
  logic          r_mem_out [DEPTH];
  logic [31:0]   r_mem_tgt [DEPTH];

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [RW-1:0] r_rr;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic [NREQ-1:0][31:0] w_pc_arr;
  logic [NREQ-1:0][31:0] w_tgt_arr;

  logic          w_empty;
  logic          w_pop;
  logic          w_space;
  logic          w_gnt_found;
  logic [RW-1:0] w_gnt_idx;
  logic [31:0]   w_gnt_pc;
  logic          w_gnt_out;
  logic [31:0]   w_gnt_tgt;
  logic          w_coal;
  logic          w_accept;
  logic          w_push;
  logic [RW-1:0] w_rr_next;

  // Per-requester views of the flat buses so the grant index selects directly.
  assign w_pc_arr  = req_pc;
  assign w_tgt_arr = req_target;

  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && !btb_stall && !flush;

  // A full queue still accepts when its head leaves in the same cycle.
  assign w_space = (r_count < CW'(DEPTH)) || w_pop;

  // Round-robin scan: first pass covers requesters rr..NREQ-1, second pass
  // wraps to 0..rr-1. The second pass only fires when the first found nothing.
  // NOTE: every variable written in a combinational block gets a default at
  // the top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_gnt_found && req_valid[i[RW-1:0]] && (i[RW-1:0] >= r_rr)) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = i[RW-1:0];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!w_gnt_found && req_valid[i[RW-1:0]]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = i[RW-1:0];
      end
    end
  end

  assign w_gnt_pc  = w_pc_arr[w_gnt_idx];
  assign w_gnt_out = req_outcome[w_gnt_idx];
  assign w_gnt_tgt = w_tgt_arr[w_gnt_idx];

`ifdef BRANCH_UPD_COALESCE_EN
  logic [PW-1:0] w_last;

  // Most recently written entry sits just behind the tail. When only one
  // entry is present and it is leaving this cycle, it cannot be merged into.
  assign w_last = r_tail - PW'(1);
  assign w_coal = w_gnt_found && !w_empty &&
                  (r_mem_pc[w_last] == w_gnt_pc) &&
                  !(w_pop && (r_count == CW'(1)));
`else
  assign w_coal = 1'b0;
`endif

  // nRST gates the grant so req_ready reads 0 while reset is held, even if
  // requesters keep their valids up.
  assign w_accept = nRST && w_gnt_found && (w_space || w_coal) && !flush;
  assign w_push   = w_accept && !w_coal;

  assign w_rr_next = (w_gnt_idx == RW'(NREQ - 1)) ? '0 : (w_gnt_idx + RW'(1));

  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_gnt_idx] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Pointers, count and round-robin pointer
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // rr holds through flush because w_accept is already false then.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_rr <= '0;
    end else if (w_accept) begin
      r_rr <= w_rr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; an entry is only observable once
  // count covers it, and the outputs are forced to 0 while empty.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem_pc[r_tail]  <= w_gnt_pc;
      r_mem_out[r_tail] <= w_gnt_out;
      r_mem_tgt[r_tail] <= w_gnt_tgt;
    end
`ifdef BRANCH_UPD_COALESCE_EN
    if (w_accept && w_coal) begin
      r_mem_out[w_last] <= w_gnt_out;
      r_mem_tgt[w_last] <= w_gnt_tgt;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign update_btb     = w_pop;
  assign update_pc      = w_empty ? 32'd0 : r_mem_pc[r_head];
  assign branch_outcome = w_empty ? 1'b0  : r_mem_out[r_head];
  assign branch_target  = w_empty ? 32'd0 : r_mem_tgt[r_head];
  assign count          = r_count;
  assign empty          = w_empty;

endmodule

// File: tb/tb_branch_update_arbiter.sv
// -----------------------------------------------------------------------------
// tb_branch_update_arbiter
//
// Self-checking bench for branch_update_arbiter (NREQ=2, DEPTH=4). A queue of
// entries plus a round-robin integer serves as the reference model. Directed
// steps come first, followed by a randomized phase in which requesters obey
// the hold-until-ready rule. Honours BRANCH_UPD_COALESCE_EN when defined.
// -----------------------------------------------------------------------------
module tb_branch_update_arbiter;

  localparam int NREQ  = 2;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic               CLK = 1'b0;
  logic               nRST;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_pc;
  logic [NREQ-1:0]    req_outcome;
  logic [NREQ*32-1:0] req_target;
  logic               flush;
  logic               btb_stall;
  logic               update_btb;
  logic [31:0]        update_pc;
  logic               branch_outcome;
  logic [31:0]        branch_target;
  logic [CW-1:0]      count;
  logic               empty;

  branch_update_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_pc         (req_pc),
    .req_outcome    (req_outcome),
    .req_target     (req_target),
    .flush          (flush),
    .btb_stall      (btb_stall),
    .update_btb     (update_btb),
    .update_pc      (update_pc),
    .branch_outcome (branch_outcome),
    .branch_target  (branch_target),
    .count          (count),
    .empty          (empty)
  );

  always #5 CLK = ~CLK;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] pc;
    logic        out;
    logic [31:0] tgt;
  } entry_t;

  entry_t q[$];
  int     m_rr;

  int n_vec = 0;
  int n_err = 0;

  // Expectations for the current cycle.
  int              e_g;
  bit              e_pop, e_coal, e_acc;
  logic [NREQ-1:0] e_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_eval();
    e_g = -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_rr + k) % NREQ;
      if (e_g < 0 && req_valid[idx]) e_g = idx;
    end
    e_pop  = !flush && (q.size() > 0) && !btb_stall;
    e_coal = 1'b0;
`ifdef BRANCH_UPD_COALESCE_EN
    if (!flush && e_g >= 0 && q.size() > 0 &&
        q[$].pc == req_pc[32*e_g +: 32] && !(e_pop && q.size() == 1))
      e_coal = 1'b1;
`endif
    e_acc   = !flush && (e_g >= 0) && ((q.size() < DEPTH) || e_pop || e_coal);
    e_ready = e_acc ? (NREQ'(1) << e_g) : '0;
  endtask

  task automatic model_update();
    entry_t e;
    if (flush) begin
      q.delete();
    end else begin
      if (e_pop) void'(q.pop_front());
      if (e_acc) begin
        e.pc  = req_pc[32*e_g +: 32];
        e.out = req_outcome[e_g];
        e.tgt = req_target[32*e_g +: 32];
        if (e_coal) begin
          q[$].out = e.out;
          q[$].tgt = e.tgt;
        end else begin
          q.push_back(e);
        end
        m_rr = (e_g + 1) % NREQ;
      end
    end
  endtask

  // Sample on the falling edge and compare every output against the model.
  task automatic sample();
    @(negedge CLK);
    model_eval();
    chk("req_ready",  req_ready,  e_ready);
    chk("update_btb", update_btb, e_pop);
    chk("update_pc",  update_pc,  (q.size() > 0) ? q[0].pc  : 32'd0);
    chk("outcome",    branch_outcome, (q.size() > 0) ? q[0].out : 1'b0);
    chk("target",     branch_target,  (q.size() > 0) ? q[0].tgt : 32'd0);
    chk("count",      count,  q.size());
    chk("empty",      empty,  q.size() == 0);
  endtask

  task automatic advance();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic set_req(input int i, input bit v, input logic [31:0] pc,
                         input bit o, input logic [31:0] tgt);
    req_valid[i]          = v;
    req_pc[32*i +: 32]     = pc;
    req_outcome[i]        = o;
    req_target[32*i +: 32] = tgt;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    q.delete();
    m_rr = 0;
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  // Random-phase requester hold state.
  bit held [NREQ];

  initial begin
    nRST        = 1'b0;
    req_valid   = '0;
    req_pc      = '0;
    req_outcome = '0;
    req_target  = '0;
    flush       = 1'b0;
    btb_stall   = 1'b0;
    q.delete();
    m_rr = 0;
    #12;
    do_reset();

    // ---- Reset state ----
    sample();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ready", req_ready, 0);
    advance();

    // ---- Single push, then drain ----
    set_req(0, 1, 32'h100, 1, 32'h200);
    sample();
    chk("push1_ready", req_ready, 2'b01);
    advance();
    req_valid = '0;
    sample();
    chk("push1_upd", update_btb, 1);
    chk("push1_pc",  update_pc,  32'h100);
    chk("push1_tgt", branch_target, 32'h200);
    advance();
    sample();
    chk("push1_empty", empty, 1);
    advance();

    // ---- Round-robin with stall ----
    do_reset();
    btb_stall = 1'b1;
    set_req(0, 1, 32'h1000, 0, 32'hA000);
    set_req(1, 1, 32'h2000, 1, 32'hB000);
    sample(); chk("rr_g0", req_ready, 2'b01); advance();
    set_req(0, 1, 32'h1004, 1, 32'hA004);
    sample(); chk("rr_g1", req_ready, 2'b10); advance();
    set_req(1, 1, 32'h2004, 0, 32'hB004);
    sample(); chk("rr_g2", req_ready, 2'b01); advance();
    set_req(0, 1, 32'h1008, 0, 32'hA008);
    sample(); chk("rr_g3", req_ready, 2'b10); advance();
    set_req(1, 1, 32'h2008, 0, 32'hB008);
    sample();
    chk("rr_full_cnt",   count, 4);
    chk("rr_full_ready", req_ready, 2'b00);
    advance();
    req_valid = '0;
    btb_stall = 1'b0;
    sample(); chk("rr_d0", update_pc, 32'h1000); advance();
    sample(); chk("rr_d1", update_pc, 32'h2000); advance();
    sample(); chk("rr_d2", update_pc, 32'h1004); advance();
    sample(); chk("rr_d3", update_pc, 32'h2004); advance();
    sample(); chk("rr_drained", empty, 1); advance();

    // ---- Full queue accepts with simultaneous pop ----
    btb_stall = 1'b1;
    for (int n = 0; n < 4; n++) begin
      set_req(0, 1, 32'h300 + 32'(4*n), n[0], 32'h900 + 32'(n));
      step();
    end
    req_valid = '0;
    set_req(1, 1, 32'h400, 1, 32'h444);
    btb_stall = 1'b0;
    sample();
    chk("fullpop_cnt0",  count, 4);
    chk("fullpop_ready", req_ready, 2'b10);
    chk("fullpop_pc",    update_pc, 32'h300);
    advance();
    req_valid = '0;
    sample();
    chk("fullpop_cnt1", count, 4);
    chk("fullpop_head", update_pc, 32'h304);
    advance();

    // ---- Flush ----
    sample(); chk("flush_pre_cnt", count, 3); advance();
    btb_stall = 1'b0;
    flush = 1'b1;
    set_req(0, 1, 32'h600, 1, 32'h660);
    set_req(1, 1, 32'h700, 0, 32'h770);
    // Queue is at 2 after the previous drain step; grow it back to 3 first.
    flush = 1'b0;
    btb_stall = 1'b1;
    req_valid = 2'b01;
    step();
    req_valid = 2'b11;
    flush = 1'b1;
    sample();
    chk("flush_cnt3",  count, 3);
    chk("flush_ready", req_ready, 2'b00);
    chk("flush_upd",   update_btb, 0);
    advance();
    flush = 1'b0;
    req_valid = '0;
    btb_stall = 1'b0;
    sample(); chk("flush_cnt0", count, 0); advance();

    // ---- Asynchronous reset mid-cycle ----
    btb_stall = 1'b1;
    set_req(0, 1, 32'h500, 1, 32'h550); step();
    set_req(0, 1, 32'h504, 1, 32'h554); step();
    btb_stall = 1'b0;
    req_valid = 2'b11;
    #2;
    chk("arst_pre_cnt", count, 2);
    nRST = 1'b0;
    #1;
    chk("arst_cnt",   count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_upd",   update_btb, 0);
    chk("arst_pc",    update_pc, 0);
    chk("arst_out",   branch_outcome, 0);
    chk("arst_tgt",   branch_target, 0);
    chk("arst_ready", req_ready, 0);
    req_valid = '0;
    do_reset();

    // ---- Coalescing of repeated PC ----
    btb_stall = 1'b1;
    set_req(0, 1, 32'h40, 1, 32'h80); step();
    set_req(0, 1, 32'h40, 0, 32'hC0); step();
    req_valid = '0;
    sample();
`ifdef BRANCH_UPD_COALESCE_EN
    chk("coal_cnt", count, 1);
`else
    chk("coal_cnt", count, 2);
`endif
    advance();
    btb_stall = 1'b0;
    sample();
    chk("coal_upd0", update_btb, 1);
`ifdef BRANCH_UPD_COALESCE_EN
    chk("coal_tgt0", branch_target, 32'hC0);
`else
    chk("coal_tgt0", branch_target, 32'h80);
`endif
    advance();
    sample();
`ifdef BRANCH_UPD_COALESCE_EN
    chk("coal_done", empty, 1);
`else
    chk("coal_tgt1", branch_target, 32'hC0);
`endif
    advance();
    step();

    // ---- Randomized phase ----
    do_reset();
    for (int i = 0; i < NREQ; i++) held[i] = 1'b0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!held[i]) begin
          if ($urandom_range(0, 2) != 0)
            set_req(i, 1, 32'h40 + 32'(4 * $urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), $urandom);
          else
            req_valid[i] = 1'b0;
        end
      end
      btb_stall = ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 31) == 0);
      sample();
      for (int i = 0; i < NREQ; i++)
        held[i] = req_valid[i] && !e_ready[i];
      advance();
    end
    flush     = 1'b0;
    btb_stall = 1'b0;
    req_valid = '0;
    for (int c = 0; c < DEPTH + 1; c++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
